// File: rtl/video_ram.sv
// 32x32 byte framebuffer with a CPU read/write port, a display fetch port and
// a fill engine that paints the whole frame with one colour.
//
// CPU handshake: cpu_we and cpu_re are single-cycle strobes with no
// back-pressure. A strobe is consumed at the rising edge where it is high.
// Read data appears on cpu_rdata after that edge and holds until the next read.
// While fill_busy is high, frame writes and CTRL writes are dropped.
`timescale 1ns/1ps
module video_ram #(
  parameter logic [15:0] BASE_ADDR  = 16'h0200,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] CTRL_ADDR  = 16'h0600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hit,
  input  logic [15:0] color_address,
  output logic [7:0]  color_data,
  output logic        fill_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [16:0] FRAME_END = {1'b0, BASE_ADDR} + 17'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] fill_count;
  logic [2:0]            fill_color;

  logic [7:0] mem [DEPTH];

  // The comparison is done in 17 bits so the upper bound cannot wrap.
  function automatic logic in_frame(input logic [15:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < FRAME_END);
  endfunction

  // Only the low address bits matter for the offset: the difference is taken
  // modulo the frame size.
  function automatic logic [DEPTH_LOG2-1:0] frame_index(input logic [15:0] a);
    return a[DEPTH_LOG2-1:0] - BASE_ADDR[DEPTH_LOG2-1:0];
  endfunction

  logic                  cpu_in_frame;
  logic                  cpu_is_ctrl;
  logic [DEPTH_LOG2-1:0] cpu_idx;
  logic                  disp_in_frame;
  logic [DEPTH_LOG2-1:0] disp_idx;
  logic                  fill_start;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [7:0]            wr_data;

  // Address decode for both ports, plus the start condition for the fill engine.
  always_comb begin
    cpu_in_frame  = in_frame(cpu_addr);
    cpu_is_ctrl   = (cpu_addr == CTRL_ADDR);
    cpu_idx       = frame_index(cpu_addr);
    disp_in_frame = in_frame(color_address);
    disp_idx      = frame_index(color_address);
    cpu_hit       = cpu_in_frame || cpu_is_ctrl;
    fill_start    = cpu_we && cpu_is_ctrl && cpu_wdata[7] && (state == IDLE);
  end

  // Single write port: the fill engine owns it in FILL, the CPU in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cpu_idx;
    wr_data = cpu_wdata;
    if (state == FILL) begin
      wr_en   = 1'b1;
      wr_idx  = fill_count;
      wr_data = {5'b0, fill_color};
    end else if (cpu_we && cpu_in_frame) begin
      wr_en = 1'b1;
    end
  end

  // Memory array write. Contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Fill FSM: one byte per cycle from index 0 to the last index, then back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill_count <= '0;
      fill_color <= '0;
      fill_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_color <= cpu_wdata[2:0];
            fill_count <= '0;
            state      <= FILL;
            fill_busy  <= 1'b1;
          end
        end
        FILL: begin
          fill_count <= fill_count + 1'b1;
          if (fill_count == LAST_IDX) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

  // Display fetch: one-cycle latency and no strobe. Reading the array in the
  // same edge as a write gives the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_data <= 8'h00;
    end else begin
      color_data <= disp_in_frame ? mem[disp_idx] : 8'h00;
    end
  end

  // CPU read: updated only on a read strobe, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= 8'h00;
    end else if (cpu_re) begin
      if (cpu_in_frame)     cpu_rdata <= mem[cpu_idx];
      else if (cpu_is_ctrl) cpu_rdata <= {fill_busy, 4'b0, fill_color};
      else                  cpu_rdata <= 8'h00;
    end
  end

endmodule

// File: tb/tb_video_ram.sv
// Directed bench for video_ram: decode, display latency, CPU reads and writes,
// the fill engine, reset during a fill and read-before-write.
`timescale 1ns/1ps
module tb_video_ram;

  localparam logic [15:0] CTRL = 16'h0600;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;
  logic [15:0] color_address;
  logic [7:0]  color_data;
  logic        fill_busy;

  int checks = 0;
  int errors = 0;

  video_ram dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_rdata     (cpu_rdata),
    .cpu_hit       (cpu_hit),
    .color_address (color_address),
    .color_data    (color_data),
    .fill_busy     (fill_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end 1 ns after a rising edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    @(posedge clk); #1;
    cpu_we    = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a;
    cpu_re   = 1'b1;
    @(posedge clk); #1;
    cpu_re   = 1'b0;
    d        = cpu_rdata;
  endtask

  task automatic disp_read(input logic [15:0] a, output logic [7:0] d);
    color_address = a;
    @(posedge clk); #1;
    d = color_data;
  endtask

  initial begin
    logic [7:0] d;
    int n;

    rst_n = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    cpu_we = 1'b0; cpu_re = 1'b0; color_address = 16'h0;
    #1;
    check("rst_cpu_rdata", 16'(cpu_rdata), 16'h00);
    check("rst_color_data", 16'(color_data), 16'h00);
    check("rst_fill_busy", 16'(fill_busy), 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then fetch through the display port with one-cycle latency.
    cpu_addr = 16'h0200; cpu_wdata = 8'h05; cpu_we = 1'b1;
    #1 check("hit_0200", 16'(cpu_hit), 16'h1);
    @(posedge clk); #1 cpu_we = 1'b0;
    color_address = 16'h0200;
    #1 check("disp_0200_before_edge", 16'(color_data), 16'h00);
    @(posedge clk); #1;
    check("disp_0200", 16'(color_data), 16'h05);

    // Frame boundaries.
    cpu_write(16'h05FF, 8'hAA);
    cpu_write(16'h01FF, 8'h77);
    cpu_addr = 16'h01FF; #1 check("hit_01ff", 16'(cpu_hit), 16'h0);
    cpu_addr = 16'h0600; #1 check("hit_ctrl", 16'(cpu_hit), 16'h1);
    cpu_addr = 16'h0601; #1 check("hit_0601", 16'(cpu_hit), 16'h0);
    cpu_addr = 16'h0400; #1 check("hit_0400", 16'(cpu_hit), 16'h1);
    cpu_read(16'h05FF, d); check("rd_05ff", 16'(d), 16'hAA);
    cpu_read(16'h01FF, d); check("rd_01ff", 16'(d), 16'h00);
    cpu_read(16'h0200, d); check("rd_0200", 16'(d), 16'h05);
    disp_read(16'h05FF, d); check("disp_05ff", 16'(d), 16'hAA);
    disp_read(16'h0600, d); check("disp_0600", 16'(d), 16'h00);
    disp_read(16'h05FF, d); check("disp_05ff_again", 16'(d), 16'hAA);
    disp_read(16'hFFFF, d); check("disp_ffff", 16'(d), 16'h00);

    // CTRL write with bit7 clear does nothing.
    cpu_write(CTRL, 8'h05);
    check("ctrl_bit7_clear_busy", 16'(fill_busy), 16'h0);
    cpu_read(CTRL, d); check("ctrl_idle_initial", 16'(d), 16'h00);

    // Fill with colour 3; writes during the fill must be dropped.
    cpu_write(CTRL, 8'h83);
    n = 0;
    while (fill_busy && n < 2000) begin
      if (n == 5)   begin cpu_addr = CTRL;    cpu_re = 1'b1; end
      if (n == 500) begin cpu_addr = 16'h0300; cpu_wdata = 8'h07; cpu_we = 1'b1; end
      if (n == 501) begin cpu_addr = CTRL;    cpu_wdata = 8'h81; cpu_we = 1'b1; end
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_re = 1'b0;
      if (n == 5) check("ctrl_busy", 16'(cpu_rdata), 16'h83);
      n++;
    end
    check("fill_busy_cycles", 16'(n), 16'd1024);
    cpu_read(CTRL, d);     check("ctrl_after_fill", 16'(d), 16'h03);
    cpu_read(16'h0200, d); check("fill_0200", 16'(d), 16'h03);
    cpu_read(16'h03E7, d); check("fill_03e7", 16'(d), 16'h03);
    cpu_read(16'h05FF, d); check("fill_05ff", 16'(d), 16'h03);
    cpu_read(16'h0300, d); check("fill_0300_write_dropped", 16'(d), 16'h03);
    disp_read(16'h0210, d); check("disp_fill_0210", 16'(d), 16'h03);

    // Write and read in the same cycle returns the pre-write byte.
    cpu_addr = 16'h0211; cpu_wdata = 8'h04; cpu_we = 1'b1; cpu_re = 1'b1;
    @(posedge clk); #1 cpu_we = 1'b0; cpu_re = 1'b0;
    check("we_re_old_value", 16'(cpu_rdata), 16'h03);
    cpu_read(16'h0211, d); check("we_re_new_value", 16'(d), 16'h04);

    // Display fetch of an index being written by the CPU in the same cycle.
    cpu_write(16'h0210, 8'h02);
    color_address = 16'h0210;
    cpu_addr = 16'h0210; cpu_wdata = 8'h06; cpu_we = 1'b1;
    @(posedge clk); #1 cpu_we = 1'b0;
    check("disp_rbw_old", 16'(color_data), 16'h02);
    @(posedge clk); #1;
    check("disp_rbw_new", 16'(color_data), 16'h06);

    // Reset in the middle of a colour-5 fill, after 100 bytes.
    cpu_read(CTRL, d); check("ctrl_before_refill", 16'(d), 16'h03);
    color_address = 16'h0200;
    cpu_write(CTRL, 8'h85);
    n = 0;
    while (fill_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("refill_reached_100", 16'(fill_busy), 16'h1);
    check("disp_during_fill", 16'(color_data), 16'h05);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_busy", 16'(fill_busy), 16'h0);
    check("midfill_rst_cpu_rdata", 16'(cpu_rdata), 16'h00);
    check("midfill_rst_color_data", 16'(color_data), 16'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("after_rst_busy", 16'(fill_busy), 16'h0);
    cpu_read(16'h0200, d); check("midfill_idx0", 16'(d), 16'h05);
    cpu_read(16'h0210, d); check("midfill_idx16", 16'(d), 16'h05);
    cpu_read(16'h0263, d); check("midfill_idx99", 16'(d), 16'h05);
    cpu_read(16'h0264, d); check("midfill_idx100", 16'(d), 16'h03);
    cpu_read(16'h0300, d); check("midfill_idx256", 16'(d), 16'h03);
    cpu_read(16'h05FF, d); check("midfill_idx1023", 16'(d), 16'h03);
    check("after_rst_still_idle", 16'(fill_busy), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_ram.md
Name: video_ram

Overview:
- Framebuffer memory that answers the display driver's pixel fetches and accepts writes from the 6502 bus.
- Holds 32x32 pixels, one byte each, mapped at CPU addresses 0x0200-0x05FF. The display fetches pixel n at address 0x0200 + 32*row + col; bits [2:0] of each byte select the colour.
- Includes a hardware fill engine, started through one control register, that writes a single colour to the whole frame.
- Sits between the CPU bus decoder and the display driver; all ports run on one clock.

Parameters:
- BASE_ADDR, 16'h0200, first framebuffer byte address.
- DEPTH_LOG2, 10, log2 of the framebuffer size in bytes (1024).
- CTRL_ADDR, 16'h0600, address of the fill control/status register.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  write strobe, one cycle per write.
- cpu_re  in  1  read strobe, one cycle per read.
- cpu_rdata  out  8  registered CPU read data.
- cpu_hit  out  1  combinational; cpu_addr decodes to the framebuffer or CTRL_ADDR.
- color_address  in  16  display fetch address.
- color_data  out  8  registered pixel byte for color_address.
- fill_busy  out  1  fill engine active.

Behaviour:
- Reset values: cpu_rdata=0, color_data=0, fill_busy=0, FSM=IDLE, fill counter=0.
- Reset does not clear memory contents.
- Reset is asserted asynchronously and released synchronously to clk.

Address decode:
- In frame iff BASE_ADDR <= addr < BASE_ADDR+1024.
- Index = (addr - BASE_ADDR)[9:0].
- cpu_hit=1 iff cpu_addr is in frame or equals CTRL_ADDR.

Display port:
- color_data <= mem[index(color_address)] every cycle, giving 1-cycle latency and no strobe.
- An out-of-frame color_address returns 8'h00 on the next cycle, e.g. 0xFFFF produced by address underflow at the left border.

CPU read:
- On a cpu_re cycle, cpu_rdata is updated on the next edge:
  - frame address: the memory byte;
  - CTRL_ADDR: {fill_busy, 4'b0, fill_color[2:0]};
  - any other address: 8'h00.
- cpu_rdata holds its value between reads.

CPU write:
- In-frame write in IDLE: mem[index] <= cpu_wdata (all 8 bits) at that edge.
- In-frame write while fill_busy: dropped with no effect.
- Write to CTRL_ADDR with bit7=1 in IDLE: latch fill_color=cpu_wdata[2:0] and go to FILL.
- CTRL write with bit7=0, or any CTRL write while busy: ignored.
- cpu_we and cpu_re asserted together: the write takes effect; read data is the pre-write value.

Read-during-write:
- Any read of an index written in the same cycle returns the old byte (read-before-write).
- This applies to both the display and CPU ports.

Fill FSM:
- IDLE -> FILL on an accepted CTRL start. fill_busy=1 from the next cycle.
- In FILL, each cycle: mem[count] <= {5'b0, fill_color}, then count++.
- When count==1023, that byte is written, count wraps to 0, the FSM returns to IDLE and fill_busy=0 next cycle.
- Exactly 1024 cycles of fill_busy=1.
- Display reads continue during the fill and may show a mix of old and new bytes.
- rst_n low mid-fill: FSM to IDLE immediately, count=0, already-written bytes stay filled, the rest are unchanged.

Memory:
- Single write port; the fill engine owns it while busy.
- Two read ports (display, CPU) may be built as duplicated RAMs sharing the write.

Test Plan:
- Write 0x05 to 0x0200, then drive color_address=0x0200 -> color_data=0x05 exactly one cycle later; cpu_hit=1 during the write.
- Write 0xAA to 0x05FF and 0x77 to 0x01FF -> 0x05FF reads 0xAA; 0x01FF has cpu_hit=0 and reads 0x00; color_address=0x0600 or 0xFFFF gives 0x00.
- Write 0x83 to 0x0600 -> fill_busy high for exactly 1024 cycles; CTRL reads 0x83 while busy and 0x03 after; 0x0200, 0x03E7 and 0x05FF all read 0x03.
- During a fill, write 0x07 to 0x0300 and 0x81 to 0x0600 -> both ignored; after the fill 0x0300 reads the fill colour and fill_color is unchanged.
- Pulse rst_n low at fill cycle 100 -> fill_busy=0 asynchronously; bytes 0-99 hold the fill colour, bytes 100-1023 keep prior data, and cpu_rdata and color_data are 0.
- Simultaneous CPU write of 0x06 to 0x0210 and display fetch of 0x0210 (old value 0x02) -> color_data=0x02 on that cycle, then 0x06 on the following fetch.
